// File: rtl/sc_regbus_arbiter.sv
// sc_regbus_arbiter: round-robin two-port sequencer for a single register-access bus.
// Each access issues one write or read strobe; reads wait RD_LAT cycles before the
// data is captured and acknowledged. All outputs are registered.
module sc_regbus_arbiter #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned RD_LAT = 1
) (
    input  logic              ACLK,
    input  logic              ARESETN,
    input  logic              REQ0,
    input  logic              REQ1,
    input  logic              WR0,
    input  logic              WR1,
    input  logic [ADDR_W-1:0] ADR0,
    input  logic [ADDR_W-1:0] ADR1,
    input  logic [31:0]       WDT0,
    input  logic [31:0]       WDT1,
    input  logic [3:0]        WEN0,
    input  logic [3:0]        WEN1,
    output logic              ACK0,
    output logic              ACK1,
    output logic [31:0]       RDT0,
    output logic [31:0]       RDT1,
    output logic              REG_WE,
    output logic [ADDR_W-1:0] REG_WADR,
    output logic [31:0]       REG_WDAT,
    output logic [3:0]        REG_WEN,
    output logic              REG_RE,
    output logic [ADDR_W-1:0] REG_RADR,
    input  logic [31:0]       REG_RDAT,
    output logic              BUSY,
    output logic [1:0]        GNT
);

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned BE_W     = 4;
    localparam int unsigned CNT_W    = 2;
    // RWAIT runs RD_LAT-1 extra cycles after ISSUE; clamp so RD_LAT=0 elaborates cleanly.
    localparam int unsigned LAT_LOAD = (RD_LAT > 0) ? RD_LAT - 1 : 0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RWAIT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic              wr;
        logic [ADDR_W-1:0] adr;
        logic [DATA_W-1:0] wdt;
        logic [BE_W-1:0]   wen;
    } acc_t;

    state_t             state_q, state_d;
    logic               last_q, last_d;
    logic               own_q, own_d;
    logic               wr_q, wr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               ack0_d, ack1_d;
    logic [DATA_W-1:0]  rdt0_d, rdt1_d;
    logic               we_d, re_d;
    logic [ADDR_W-1:0]  wadr_d, radr_d;
    logic [DATA_W-1:0]  wdat_d;
    logic [BE_W-1:0]    wen_d;
    logic               busy_d;
    logic [1:0]         gnt_d;
    logic               capture;

    logic               sel;
    acc_t               acc0, acc1, acc;

    // Request fields bundled per port.
    assign acc0 = '{wr: WR0, adr: ADR0, wdt: WDT0, wen: WEN0};
    assign acc1 = '{wr: WR1, adr: ADR1, wdt: WDT1, wen: WEN1};

    // Round-robin pick: on contention the port not granted last wins.
    always_comb begin
        sel = (REQ0 && REQ1) ? ~last_q : REQ1;
        acc = sel ? acc1 : acc0;
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        own_d   = own_q;
        wr_d    = wr_q;
        cnt_d   = cnt_q;
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;
        we_d    = 1'b0;
        re_d    = 1'b0;
        rdt0_d  = RDT0;
        rdt1_d  = RDT1;
        wadr_d  = REG_WADR;
        wdat_d  = REG_WDAT;
        wen_d   = REG_WEN;
        radr_d  = REG_RADR;
        gnt_d   = GNT;
        capture = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (REQ0 || REQ1) begin
                    state_d = S_ISSUE;
                    own_d   = sel;
                    last_d  = sel;
                    wr_d    = acc.wr;
                    gnt_d   = sel ? 2'b10 : 2'b01;
                    if (acc.wr) begin
                        // Write strobe and its ACK land together in ISSUE.
                        we_d   = 1'b1;
                        wadr_d = acc.adr;
                        wdat_d = acc.wdt;
                        wen_d  = acc.wen;
                        ack0_d = ~sel;
                        ack1_d = sel;
                    end else begin
                        re_d   = 1'b1;
                        radr_d = acc.adr;
                    end
                end
            end
            S_ISSUE: begin
                if (wr_q) begin
                    state_d = S_IDLE;
                end else if (RD_LAT == 0) begin
                    capture = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d   = CNT_W'(LAT_LOAD);
                    state_d = S_RWAIT;
                end
            end
            S_RWAIT: begin
                if (cnt_q == '0) begin
                    capture = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Read data goes only to the owner; its ACK is visible with the data in DONE.
        if (capture) begin
            if (own_q) begin
                rdt1_d = REG_RDAT;
                ack1_d = 1'b1;
            end else begin
                rdt0_d = REG_RDAT;
                ack0_d = 1'b1;
            end
        end

        busy_d = (state_d != S_IDLE);
        if (!busy_d) begin
            gnt_d = '0;
        end
    end

    // State and registered outputs.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q  <= S_IDLE;
            last_q   <= 1'b1;
            own_q    <= 1'b0;
            wr_q     <= 1'b0;
            cnt_q    <= '0;
            ACK0     <= 1'b0;
            ACK1     <= 1'b0;
            RDT0     <= '0;
            RDT1     <= '0;
            REG_WE   <= 1'b0;
            REG_WADR <= '0;
            REG_WDAT <= '0;
            REG_WEN  <= '0;
            REG_RE   <= 1'b0;
            REG_RADR <= '0;
            BUSY     <= 1'b0;
            GNT      <= '0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            own_q    <= own_d;
            wr_q     <= wr_d;
            cnt_q    <= cnt_d;
            ACK0     <= ack0_d;
            ACK1     <= ack1_d;
            RDT0     <= rdt0_d;
            RDT1     <= rdt1_d;
            REG_WE   <= we_d;
            REG_WADR <= wadr_d;
            REG_WDAT <= wdat_d;
            REG_WEN  <= wen_d;
            REG_RE   <= re_d;
            REG_RADR <= radr_d;
            BUSY     <= busy_d;
            GNT      <= gnt_d;
        end
    end

endmodule

// File: tb/tb_sc_regbus_arbiter.sv
// Bench for sc_regbus_arbiter: three instances (RD_LAT 0, 1, 3) share one set of
// requester inputs and are compared every cycle against a transaction-level model.
module tb_sc_regbus_arbiter;

    localparam int ADDR_W = 16;
    localparam int NI     = 3;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              req0, req1, wr0, wr1;
    logic [ADDR_W-1:0] adr0, adr1;
    logic [31:0]       wdt0, wdt1;
    logic [3:0]        wen0, wen1;

    logic              ack0 [NI];
    logic              ack1 [NI];
    logic [31:0]       rdt0 [NI];
    logic [31:0]       rdt1 [NI];
    logic              we   [NI];
    logic [ADDR_W-1:0] wadr [NI];
    logic [31:0]       wdat [NI];
    logic [3:0]        wen  [NI];
    logic              re   [NI];
    logic [ADDR_W-1:0] radr [NI];
    logic [31:0]       rdat [NI];
    logic              busy [NI];
    logic [1:0]        gnt  [NI];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    function automatic int lat_of(input int i);
        return (i == 0) ? 0 : ((i == 1) ? 1 : 3);
    endfunction

    // Register-file contents as seen by the bus.
    function automatic logic [31:0] rf_word(input logic [ADDR_W-1:0] a);
        if (a == 16'h0004) return 32'hDEAD_BEEF;
        return {a ^ 16'h5A5A, a};
    endfunction

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 0 : ((g == 1) ? 1 : 3);
        int rd_age;

        // Register file returns valid data only LAT cycles after the read strobe.
        always @(posedge clk or negedge rst_n) begin
            if (!rst_n)                          rd_age <= 0;
            else if (re[g])                      rd_age <= 1;
            else if (rd_age != 0 && rd_age < 8)  rd_age <= rd_age + 1;
        end

        assign rdat[g] = ((LAT == 0) ? re[g] : (rd_age == LAT)) ? rf_word(radr[g]) : 32'h0BAD_F00D;

        sc_regbus_arbiter #(.ADDR_W(ADDR_W), .RD_LAT(LAT)) u_dut (
            .ACLK(clk), .ARESETN(rst_n),
            .REQ0(req0), .REQ1(req1), .WR0(wr0), .WR1(wr1),
            .ADR0(adr0), .ADR1(adr1), .WDT0(wdt0), .WDT1(wdt1),
            .WEN0(wen0), .WEN1(wen1),
            .ACK0(ack0[g]), .ACK1(ack1[g]), .RDT0(rdt0[g]), .RDT1(rdt1[g]),
            .REG_WE(we[g]), .REG_WADR(wadr[g]), .REG_WDAT(wdat[g]), .REG_WEN(wen[g]),
            .REG_RE(re[g]), .REG_RADR(radr[g]), .REG_RDAT(rdat[g]),
            .BUSY(busy[g]), .GNT(gnt[g])
        );
    end

    // Model: an access occupies phases 1..len after its grant cycle
    // (len = 1 for writes, 2+RD_LAT for reads); a new grant needs an idle cycle.
    bit                m_act  [NI];
    int                m_k    [NI];
    int                m_own  [NI];
    int                m_last [NI];
    bit                m_wr   [NI];
    logic [ADDR_W-1:0] m_adr  [NI];
    logic [ADDR_W-1:0] m_wadr [NI];
    logic [ADDR_W-1:0] m_radr [NI];
    logic [31:0]       m_wdat [NI];
    logic [3:0]        m_wen  [NI];
    logic [31:0]       m_rdt0 [NI];
    logic [31:0]       m_rdt1 [NI];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            m_act[i] = 1'b0; m_k[i] = 0; m_own[i] = 0; m_last[i] = 1; m_wr[i] = 1'b0;
            m_adr[i] = '0; m_wadr[i] = '0; m_radr[i] = '0; m_wdat[i] = '0; m_wen[i] = '0;
            m_rdt0[i] = '0; m_rdt1[i] = '0;
        end
    endtask

    task automatic model_advance();
        for (int i = 0; i < NI; i++) begin
            int len;
            int p;
            if (!rst_n) continue;
            if (m_act[i]) begin
                len = m_wr[i] ? 1 : 2 + lat_of(i);
                m_k[i]++;
                if (!m_wr[i] && m_k[i] == 2 + lat_of(i)) begin
                    if (m_own[i] == 1) m_rdt1[i] = rf_word(m_adr[i]);
                    else               m_rdt0[i] = rf_word(m_adr[i]);
                end
                if (m_k[i] > len) begin
                    m_act[i] = 1'b0;
                    m_k[i]   = 0;
                end
            end else if (req0 || req1) begin
                p = (req0 && req1) ? 1 - m_last[i] : (req1 ? 1 : 0);
                m_act[i]  = 1'b1;
                m_k[i]    = 1;
                m_own[i]  = p;
                m_last[i] = p;
                m_wr[i]   = (p == 1) ? wr1 : wr0;
                m_adr[i]  = (p == 1) ? adr1 : adr0;
                if (m_wr[i]) begin
                    m_wadr[i] = m_adr[i];
                    m_wdat[i] = (p == 1) ? wdt1 : wdt0;
                    m_wen[i]  = (p == 1) ? wen1 : wen0;
                end else begin
                    m_radr[i] = m_adr[i];
                end
            end
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < NI; i++) begin
            string pre;
            int    len;
            bit    a;
            pre = $sformatf("L%0d.", lat_of(i));
            a   = m_act[i];
            len = m_wr[i] ? 1 : 2 + lat_of(i);
            check({pre, "busy"}, 64'(busy[i]), 64'(a));
            check({pre, "gnt"},  64'(gnt[i]),  64'(a ? ((m_own[i] == 1) ? 2 : 1) : 0));
            check({pre, "we"},   64'(we[i]),   64'(a && m_wr[i] && m_k[i] == 1));
            check({pre, "re"},   64'(re[i]),   64'(a && !m_wr[i] && m_k[i] == 1));
            check({pre, "ack0"}, 64'(ack0[i]), 64'(a && m_own[i] == 0 && m_k[i] == len));
            check({pre, "ack1"}, 64'(ack1[i]), 64'(a && m_own[i] == 1 && m_k[i] == len));
            check({pre, "rdt0"}, 64'(rdt0[i]), 64'(m_rdt0[i]));
            check({pre, "rdt1"}, 64'(rdt1[i]), 64'(m_rdt1[i]));
            check({pre, "wadr"}, 64'(wadr[i]), 64'(m_wadr[i]));
            check({pre, "wdat"}, 64'(wdat[i]), 64'(m_wdat[i]));
            check({pre, "wen"},  64'(wen[i]),  64'(m_wen[i]));
            check({pre, "radr"}, 64'(radr[i]), 64'(m_radr[i]));
        end
    endtask

    // One clock: model advances at the edge, DUTs are compared mid-cycle.
    task automatic step();
        @(posedge clk);
        model_advance();
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int first     [NI];
        int cnt       [NI][2];
        int first_gnt [NI];

        rst_n = 1'b0;
        req0 = 1'b0; req1 = 1'b0; wr0 = 1'b0; wr1 = 1'b0;
        adr0 = '0; adr1 = '0; wdt0 = '0; wdt1 = '0; wen0 = '0; wen1 = '0;
        model_reset();
        step();
        step();
        rst_n = 1'b1;
        step();

        // Single write on port 0.
        req0 = 1'b1; wr0 = 1'b1; adr0 = 16'h0010; wdt0 = 32'hA5A5_0001; wen0 = 4'hF;
        step();
        for (int i = 0; i < NI; i++) begin
            check("wr.we",   64'(we[i]),   64'(1));
            check("wr.ack0", 64'(ack0[i]), 64'(1));
            check("wr.wadr", 64'(wadr[i]), 64'(16'h0010));
            check("wr.wdat", 64'(wdat[i]), 64'(32'hA5A5_0001));
        end
        req0 = 1'b0;
        step();
        for (int i = 0; i < NI; i++) check("wr.busy_c2", 64'(busy[i]), 64'(0));
        step();

        // Port-1 read of 0x0004 with REQ1 dropped at cycle 1.
        for (int i = 0; i < NI; i++) first[i] = -1;
        req1 = 1'b1; wr1 = 1'b0; adr1 = 16'h0004;
        for (int c = 1; c <= 8; c++) begin
            step();
            if (c == 1) req1 = 1'b0;
            for (int i = 0; i < NI; i++) if (first[i] < 0 && ack1[i]) first[i] = c;
        end
        for (int i = 0; i < NI; i++) begin
            check($sformatf("rd.ack1_cycle L%0d", lat_of(i)), 64'(first[i]), 64'(2 + lat_of(i)));
            check("rd.rdt1", 64'(rdt1[i]), 64'(32'hDEAD_BEEF));
            check("rd.rdt0", 64'(rdt0[i]), 64'(0));
        end

        // Contention: both ports hold write requests until four ACKs each.
        for (int i = 0; i < NI; i++) begin
            cnt[i][0] = 0; cnt[i][1] = 0; first_gnt[i] = 0;
        end
        req0 = 1'b1; req1 = 1'b1; wr0 = 1'b1; wr1 = 1'b1;
        adr0 = 16'h0020; adr1 = 16'h0030; wdt0 = $urandom; wdt1 = $urandom;
        wen0 = 4'hF; wen1 = 4'h3;
        for (int c = 0; c < 30 && (req0 || req1); c++) begin
            step();
            for (int i = 0; i < NI; i++) begin
                if (first_gnt[i] == 0 && gnt[i] != 2'b00) first_gnt[i] = int'(gnt[i]);
                cnt[i][0] += int'(ack0[i]);
                cnt[i][1] += int'(ack1[i]);
            end
            if (ack0[0]) begin
                wdt0 = $urandom; adr0 = adr0 + 16'h0004;
                if (cnt[0][0] >= 4) req0 = 1'b0;
            end
            if (ack1[0]) begin
                wdt1 = $urandom; adr1 = adr1 + 16'h0004;
                if (cnt[0][1] >= 4) req1 = 1'b0;
            end
        end
        for (int i = 0; i < NI; i++) begin
            check("cont.acks0", 64'(cnt[i][0]), 64'(4));
            check("cont.acks1", 64'(cnt[i][1]), 64'(4));
            check("cont.first_gnt", 64'(first_gnt[i]), 64'(1));
        end
        step();

        // Partial-strobe writes: WEN 0x0 then 0x4.
        req0 = 1'b1; wr0 = 1'b1; adr0 = 16'h0040; wdt0 = 32'h1234_5678; wen0 = 4'h0;
        step();
        for (int i = 0; i < NI; i++) begin
            check("pw0.we",   64'(we[i]),   64'(1));
            check("pw0.wen",  64'(wen[i]),  64'(0));
            check("pw0.ack0", 64'(ack0[i]), 64'(1));
        end
        req0 = 1'b0;
        step();
        req0 = 1'b1; wen0 = 4'h4;
        step();
        for (int i = 0; i < NI; i++) begin
            check("pw4.we",   64'(we[i]),   64'(1));
            check("pw4.wen",  64'(wen[i]),  64'(4));
            check("pw4.ack0", 64'(ack0[i]), 64'(1));
        end
        req0 = 1'b0;
        step();
        step();

        // Reset in the middle of a read (RWAIT for RD_LAT=3).
        req1 = 1'b1; wr1 = 1'b0; adr1 = 16'h0008;
        step();
        req1 = 1'b0;
        step();
        #1 rst_n = 1'b0;
        model_reset();
        #1 compare_all();
        for (int i = 0; i < NI; i++) begin
            check("rst.re",   64'(re[i]),   64'(0));
            check("rst.ack1", 64'(ack1[i]), 64'(0));
            check("rst.busy", 64'(busy[i]), 64'(0));
        end
        step();
        step();
        rst_n = 1'b1;
        req0 = 1'b1; req1 = 1'b1; wr0 = 1'b1; wr1 = 1'b1;
        step();
        for (int i = 0; i < NI; i++) check("rst.first_gnt", 64'(gnt[i]), 64'(2'b01));
        req0 = 1'b0;
        for (int c = 0; c < 6; c++) begin
            step();
            if (ack1[0]) req1 = 1'b0;
        end

        // Randomized traffic.
        for (int c = 0; c < 400; c++) begin
            if (!req0 && $urandom_range(2) == 0) begin
                req0 = 1'b1; wr0 = 1'($urandom_range(1));
                adr0 = 16'($urandom_range(7) * 4); wdt0 = $urandom; wen0 = 4'($urandom);
            end
            if (!req1 && $urandom_range(2) == 0) begin
                req1 = 1'b1; wr1 = 1'($urandom_range(1));
                adr1 = 16'($urandom_range(7) * 4); wdt1 = $urandom; wen1 = 4'($urandom);
            end
            step();
            if (req0 && (ack0[0] || $urandom_range(7) == 0)) req0 = 1'b0;
            if (req1 && (ack1[0] || $urandom_range(7) == 0)) req1 = 1'b0;
        end
        req0 = 1'b0; req1 = 1'b0;
        for (int c = 0; c < 8; c++) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
